// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the turn sequencer of the cat-vs-dog game.
//   turn_state_t       : turn FSM states
//   MAX_HP_DEF         : default starting HP per player
//   TIMEOUT_60MHZ_10S  : 10 s aim limit expressed in clk60MHz cycles
//   next_alive()       : cyclic search for the next live player
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AIM,
        ST_FLIGHT,
        ST_RESOLVE,
        ST_GAME_OVER
    } turn_state_t;

    localparam int MAX_HP_DEF        = 100;
    localparam int TIMEOUT_60MHZ_10S = 600000000;
    localparam int MAX_PLAYERS       = 8;

    // Returns the first set bit of mask strictly after cur, wrapping at num.
    // The search also reaches cur itself last, so with a single live player
    // it returns that player's index. With an empty mask cur is returned.
    function automatic logic [2:0] next_alive(
        input logic [7:0] mask,
        input logic [2:0] cur,
        input int         num
    );
        logic [2:0] result;
        logic       found;
        int         idx;
        result = cur;
        found  = 1'b0;
        for (int k = 1; k <= MAX_PLAYERS; k++) begin
            idx = (int'(cur) + k) % num;
            if (!found && (k <= num) && mask[idx[2:0]]) begin
                result = idx[2:0];
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hp_bank.sv
// ---------------------------------------------------------------------------
// hp_bank
// Per-player HP registers with saturating damage, reload and alive vector.
// Ports:
//   clk60MHz   in  system clock
//   rst        in  synchronous active-low reset (reloads MAX_HP)
//   reload     in  reload every player to MAX_HP (new game)
//   hit_en     in  apply hit_damage to hit_player this cycle
//   hit_player in  index of the player hit
//   hit_damage in  damage amount
//   hp         out packed HP, player i at [i*HP_W +: HP_W]
//   alive      out bit i set while player i has HP > 0
// ---------------------------------------------------------------------------
module hp_bank
    import game_pkg::*;
#(
    parameter  int NUM_PLAYERS = 2,
    parameter  int HP_W        = 7,
    parameter  int MAX_HP      = MAX_HP_DEF,
    localparam int PW          = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                        clk60MHz,
    input  logic                        rst,
    input  logic                        reload,
    input  logic                        hit_en,
    input  logic [PW-1:0]               hit_player,
    input  logic [HP_W-1:0]             hit_damage,
    output logic [NUM_PLAYERS*HP_W-1:0] hp,
    output logic [NUM_PLAYERS-1:0]      alive
);

    localparam logic [HP_W-1:0] FULL_HP = HP_W'(MAX_HP);

    logic [NUM_PLAYERS*HP_W-1:0] hp_next;
    logic [NUM_PLAYERS-1:0]      alive_next;

    // Out-of-range indices never match any slot, and dead players are
    // skipped, so such hits fall through without effect. alive is derived
    // from the next HP so it stays in step with the hp register.
    always_comb begin
        hp_next    = hp;
        alive_next = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (hit_en && (hit_player == PW'(i)) && alive[i]) begin
                if (hp[i*HP_W +: HP_W] > hit_damage) begin
                    hp_next[i*HP_W +: HP_W] = hp[i*HP_W +: HP_W] - hit_damage;
                end else begin
                    hp_next[i*HP_W +: HP_W] = '0;
                end
            end
            alive_next[i] = |hp_next[i*HP_W +: HP_W];
        end
    end

    always_ff @(posedge clk60MHz) begin
        if (!rst || reload) begin
            hp    <= {NUM_PLAYERS{FULL_HP}};
            alive <= '1;
        end else begin
            hp    <= hp_next;
            alive <= alive_next;
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// ---------------------------------------------------------------------------
// turn_sequencer
// Turn sequencing for NUM_PLAYERS players: aim / flight / resolve cycle,
// HP tracking through hp_bank, skipping of eliminated players and winner or
// draw detection. Everything runs in the clk60MHz domain.
// Optional feature macro: TURN_TIMEOUT_EN adds an aim time limit; when it
// expires the turn is forfeited. Without it timeout is constant 0.
// Ports:
//   clk60MHz       in  system clock
//   rst            in  synchronous active-low reset
//   player_ready   in  per-player ready level
//   new_game       in  pulse, restarts from game over
//   throw_start    in  pulse, current player released a throw
//   throw_end      in  pulse, projectile landed or left the screen
//   hit_valid      in  pulse, hit reported this cycle
//   hit_player     in  index of the player hit
//   hit_damage     in  damage amount
//   current_player out player whose turn it is
//   aim_active     out current player may throw
//   turn           out completed-turn counter
//   turn_pulse     out one-cycle pulse on each turn advance
//   hp             out packed HP, player i at [i*HP_W +: HP_W]
//   alive          out bit i set while player i has HP > 0
//   game_over      out game finished
//   draw           out game finished with nobody alive
//   winner         out winning index while game_over && !draw
//   timeout        out one-cycle pulse on aim timeout
// ---------------------------------------------------------------------------
module turn_sequencer
    import game_pkg::*;
#(
    parameter  int NUM_PLAYERS    = 2,
    parameter  int HP_W           = 7,
    parameter  int MAX_HP         = MAX_HP_DEF,
    parameter  int TURN_W         = 3,
    parameter  int TIMEOUT_CYCLES = TIMEOUT_60MHZ_10S,
    localparam int PW             = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                        clk60MHz,
    input  logic                        rst,
    input  logic [NUM_PLAYERS-1:0]      player_ready,
    input  logic                        new_game,
    input  logic                        throw_start,
    input  logic                        throw_end,
    input  logic                        hit_valid,
    input  logic [PW-1:0]               hit_player,
    input  logic [HP_W-1:0]             hit_damage,
    output logic [PW-1:0]               current_player,
    output logic                        aim_active,
    output logic [TURN_W-1:0]           turn,
    output logic                        turn_pulse,
    output logic [NUM_PLAYERS*HP_W-1:0] hp,
    output logic [NUM_PLAYERS-1:0]      alive,
    output logic                        game_over,
    output logic                        draw,
    output logic [PW-1:0]               winner,
    output logic                        timeout
);

    turn_state_t state;

    logic        all_ready;
    logic        hit_en;
    logic        reload;
    logic [3:0]  alive_count;
    logic [PW-1:0] next_pick;

`ifdef TURN_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] aim_timer;
`endif

    assign all_ready   = &player_ready;
    assign hit_en      = (state == ST_FLIGHT) && hit_valid;
    assign reload      = (state == ST_GAME_OVER) && new_game;
    assign alive_count = 4'($countones(alive));

    // With one survivor the cyclic search lands on that survivor, so the
    // same lookup serves both as next player and as winner index.
    assign next_pick = PW'(next_alive(8'(alive), 3'(current_player), NUM_PLAYERS));

    hp_bank #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .HP_W        (HP_W),
        .MAX_HP      (MAX_HP)
    ) u_hp_bank (
        .clk60MHz   (clk60MHz),
        .rst        (rst),
        .reload     (reload),
        .hit_en     (hit_en),
        .hit_player (hit_player),
        .hit_damage (hit_damage),
        .hp         (hp),
        .alive      (alive)
    );

    // Turn FSM. Pulsed outputs default low every cycle; the aim timer is
    // cleared whenever the FSM is not staying in AIM, which covers both
    // entry into AIM and a pause.
    always_ff @(posedge clk60MHz) begin
        if (!rst) begin
            state          <= ST_IDLE;
            current_player <= '0;
            turn           <= '0;
            aim_active     <= 1'b0;
            turn_pulse     <= 1'b0;
            game_over      <= 1'b0;
            draw           <= 1'b0;
            winner         <= '0;
            timeout        <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            aim_timer      <= '0;
`endif
        end else begin
            turn_pulse <= 1'b0;
            timeout    <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            aim_timer  <= '0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (all_ready) begin
                        state      <= ST_AIM;
                        aim_active <= 1'b1;
                    end
                end

                ST_AIM: begin
                    if (!all_ready) begin
                        state      <= ST_IDLE;
                        aim_active <= 1'b0;
                    end else if (throw_start) begin
                        state      <= ST_FLIGHT;
                        aim_active <= 1'b0;
                    end else begin
`ifdef TURN_TIMEOUT_EN
                        if (aim_timer == TMR_LAST) begin
                            timeout    <= 1'b1;
                            aim_active <= 1'b0;
                            state      <= ST_RESOLVE;
                        end else begin
                            aim_timer <= aim_timer + 1'b1;
                        end
`endif
                    end
                end

                ST_FLIGHT: begin
                    if (throw_end) begin
                        state <= ST_RESOLVE;
                    end
                end

                ST_RESOLVE: begin
                    if (alive_count == 4'd0) begin
                        draw      <= 1'b1;
                        game_over <= 1'b1;
                        state     <= ST_GAME_OVER;
                    end else if (alive_count == 4'd1) begin
                        winner    <= next_pick;
                        game_over <= 1'b1;
                        state     <= ST_GAME_OVER;
                    end else begin
                        current_player <= next_pick;
                        turn           <= turn + 1'b1;
                        turn_pulse     <= 1'b1;
                        aim_active     <= 1'b1;
                        state          <= ST_AIM;
                    end
                end

                ST_GAME_OVER: begin
                    if (new_game) begin
                        state          <= ST_IDLE;
                        current_player <= '0;
                        turn           <= '0;
                        game_over      <= 1'b0;
                        draw           <= 1'b0;
                        winner         <= '0;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    aim_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// ---------------------------------------------------------------------------
// tb_turn_sequencer
// Self-checking bench for turn_sequencer with three players and MAX_HP=100.
// A small game model predicts HP, next player and turn count; expected turn
// advances are queued when a throw is driven and retired when turn_pulse
// appears. With TURN_TIMEOUT_EN the aim time limit is exercised as well.
// ---------------------------------------------------------------------------
module tb_turn_sequencer;

    localparam int NP   = 3;
    localparam int HPW  = 7;
    localparam int MHP  = 100;
    localparam int TW   = 3;
    localparam int TOUT = 16;

    logic            clk60MHz;
    logic            rst;
    logic [NP-1:0]   player_ready;
    logic            new_game;
    logic            throw_start;
    logic            throw_end;
    logic            hit_valid;
    logic [1:0]      hit_player;
    logic [HPW-1:0]  hit_damage;
    logic [1:0]      current_player;
    logic            aim_active;
    logic [TW-1:0]   turn;
    logic            turn_pulse;
    logic [NP*HPW-1:0] hp;
    logic [NP-1:0]   alive;
    logic            game_over;
    logic            draw;
    logic [1:0]      winner;
    logic            timeout;

    typedef struct {
        int          cp;
        int          turnNum;
        logic [31:0] hpVec;
    } expect_t;

    expect_t sbq[$];

    int errorCount = 0;
    int checkCount = 0;
    int modelHp[NP];
    int modelCp;
    int modelTurn;

    turn_sequencer #(
        .NUM_PLAYERS    (NP),
        .HP_W           (HPW),
        .MAX_HP         (MHP),
        .TURN_W         (TW),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk60MHz       (clk60MHz),
        .rst            (rst),
        .player_ready   (player_ready),
        .new_game       (new_game),
        .throw_start    (throw_start),
        .throw_end      (throw_end),
        .hit_valid      (hit_valid),
        .hit_player     (hit_player),
        .hit_damage     (hit_damage),
        .current_player (current_player),
        .aim_active     (aim_active),
        .turn           (turn),
        .turn_pulse     (turn_pulse),
        .hp             (hp),
        .alive          (alive),
        .game_over      (game_over),
        .draw           (draw),
        .winner         (winner),
        .timeout        (timeout)
    );

    initial begin
        clk60MHz = 1'b0;
        forever #5 clk60MHz = ~clk60MHz;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelHpPacked();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) begin
            r = r | (32'(modelHp[i] & 8'h7f) << (i * HPW));
        end
        return r;
    endfunction

    function automatic logic [31:0] modelAlive();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) begin
            if (modelHp[i] > 0) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic int modelNext(input int cur);
        for (int k = 1; k <= NP; k++) begin
            if (modelHp[(cur + k) % NP] > 0) return (cur + k) % NP;
        end
        return cur;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NP; i++) modelHp[i] = MHP;
        modelCp   = 0;
        modelTurn = 0;
    endtask

    task automatic modelHit(input int p, input int d);
        if (p < NP && modelHp[p] > 0) begin
            modelHp[p] = (modelHp[p] > d) ? modelHp[p] - d : 0;
        end
    endtask

    // Scoreboard: every turn_pulse retires one queued expectation.
    always @(negedge clk60MHz) begin
        if (rst && turn_pulse) begin
            if (sbq.size() == 0) begin
                checkOutput("sb_unexpected_pulse", 32'(sbq.size()), 32'd1);
            end else begin
                expect_t e;
                e = sbq.pop_front();
                checkOutput("sb_current_player", 32'(current_player), 32'(e.cp));
                checkOutput("sb_turn", 32'(turn), 32'(e.turnNum));
                checkOutput("sb_hp", 32'(hp), e.hpVec);
            end
        end
    end

    task automatic waitAim();
        for (int i = 0; i < 50 && !aim_active; i++) @(negedge clk60MHz);
        if (!aim_active) checkOutput("aim_wait_expired", 32'(aim_active), 32'd1);
    endtask

    // Follows the resolve cycle: either a queued turn advance two edges
    // after throw_end, or a game-over verdict.
    task automatic resolveModel();
        int aliveCnt;
        aliveCnt = 0;
        for (int i = 0; i < NP; i++) if (modelHp[i] > 0) aliveCnt++;
        if (aliveCnt >= 2) begin
            expect_t e;
            modelCp   = modelNext(modelCp);
            modelTurn = (modelTurn + 1) % (1 << TW);
            e.cp = modelCp;
            e.turnNum = modelTurn;
            e.hpVec = modelHpPacked();
            sbq.push_back(e);
            @(negedge clk60MHz);
            checkOutput("pulse_two_edges", 32'(turn_pulse), 32'd1);
            checkOutput("timeout_quiet", 32'(timeout), 32'd0);
            @(negedge clk60MHz);
            checkOutput("pulse_single_cycle", 32'(turn_pulse), 32'd0);
            checkOutput("aim_resumed", 32'(aim_active), 32'd1);
        end else begin
            @(negedge clk60MHz);
            checkOutput("game_over_set", 32'(game_over), 32'd1);
            checkOutput("draw_flag", 32'(draw), (aliveCnt == 0) ? 32'd1 : 32'd0);
            if (aliveCnt == 1) checkOutput("winner_idx", 32'(winner), 32'(modelNext(modelCp)));
            checkOutput("game_over_no_pulse", 32'(turn_pulse), 32'd0);
        end
    endtask

    // One full throw: release, up to three hits (the last one lands in the
    // same cycle as throw_end), then the resolve step.
    task automatic applyStimulus(input int nHits, input int p0, input int d0,
                                 input int p1, input int d1, input int p2, input int d2);
        int pl[3];
        int dm[3];
        pl[0] = p0; pl[1] = p1; pl[2] = p2;
        dm[0] = d0; dm[1] = d1; dm[2] = d2;
        waitAim();
        throw_start = 1'b1;
        @(negedge clk60MHz);
        throw_start = 1'b0;
        checkOutput("aim_drop_on_throw", 32'(aim_active), 32'd0);
        for (int h = 0; h < nHits; h++) begin
            hit_valid  = 1'b1;
            hit_player = 2'(pl[h]);
            hit_damage = 7'(dm[h]);
            modelHit(pl[h], dm[h]);
            if (h == nHits - 1) throw_end = 1'b1;
            @(negedge clk60MHz);
        end
        if (nHits == 0) begin
            throw_end = 1'b1;
            @(negedge clk60MHz);
        end
        hit_valid = 1'b0;
        throw_end = 1'b0;
        checkOutput("hp_after_flight", 32'(hp), modelHpPacked());
        checkOutput("alive_after_flight", 32'(alive), modelAlive());
        checkOutput("pulse_not_early", 32'(turn_pulse), 32'd0);
        resolveModel();
    endtask

    initial begin
        rst          = 1'b0;
        player_ready = '0;
        new_game     = 1'b0;
        throw_start  = 1'b0;
        throw_end    = 1'b0;
        hit_valid    = 1'b0;
        hit_player   = '0;
        hit_damage   = '0;
        modelReset();

        repeat (2) @(negedge clk60MHz);
        rst = 1'b1;
        @(negedge clk60MHz);
        checkOutput("rst_hp", 32'(hp), modelHpPacked());
        checkOutput("rst_alive", 32'(alive), 32'h7);
        checkOutput("rst_flags", {26'd0, aim_active, turn_pulse, game_over, draw, timeout, 1'b0}, 32'd0);
        checkOutput("rst_player_turn", {current_player, turn, winner}, '0);

        player_ready = 3'b111;
        @(negedge clk60MHz);
        checkOutput("aim_after_ready", 32'(aim_active), 32'd1);

        // P0 hits P2 for 30; P1 hits P0 for 10.
        applyStimulus(1, 2, 30, 0, 0, 0, 0);
        applyStimulus(1, 0, 10, 0, 0, 0, 0);
        // P2: out-of-range index ignored, then P1 hit together with throw_end.
        applyStimulus(2, 3, 50, 1, 5, 0, 0);
        // P0 overkills P1; next player must skip to P2.
        applyStimulus(1, 1, 120, 0, 0, 0, 0);
        checkOutput("skip_dead_player", 32'(current_player), 32'd2);

        // Pause in AIM with a simultaneous throw_start: pause wins.
        player_ready = 3'b011;
        throw_start  = 1'b1;
        @(negedge clk60MHz);
        throw_start = 1'b0;
        checkOutput("pause_aim_off", 32'(aim_active), 32'd0);
        @(negedge clk60MHz);
        checkOutput("pause_hp_kept", 32'(hp), modelHpPacked());
        checkOutput("pause_still_idle", 32'(aim_active), 32'd0);
        player_ready = 3'b111;
        @(negedge clk60MHz);
        checkOutput("resume_aim", 32'(aim_active), 32'd1);
        checkOutput("resume_player", 32'(current_player), 32'd2);

        // P2: hit on dead P1 ignored, P0 damaged; then P0 finishes P2.
        applyStimulus(2, 1, 10, 0, 20, 0, 0);
        applyStimulus(1, 2, 70, 0, 0, 0, 0);

        // Events during game over change nothing.
        hit_valid   = 1'b1;
        hit_player  = 2'd0;
        hit_damage  = 7'd50;
        throw_start = 1'b1;
        throw_end   = 1'b1;
        repeat (2) @(negedge clk60MHz);
        hit_valid   = 1'b0;
        throw_start = 1'b0;
        throw_end   = 1'b0;
        checkOutput("over_hp_frozen", 32'(hp), modelHpPacked());
        checkOutput("over_held", {30'd0, game_over, aim_active}, 32'h2);
        checkOutput("over_winner_held", 32'(winner), 32'd0);

        new_game = 1'b1;
        @(negedge clk60MHz);
        new_game = 1'b0;
        modelReset();
        checkOutput("newgame_hp", 32'(hp), modelHpPacked());
        checkOutput("newgame_state", {current_player, turn, winner, game_over, draw, aim_active}, '0);
        @(negedge clk60MHz);
        checkOutput("newgame_aim", 32'(aim_active), 32'd1);

        // Everybody dies in one flight: draw.
        applyStimulus(3, 1, 100, 2, 100, 0, 100);
        checkOutput("draw_alive", 32'(alive), 32'd0);

`ifdef TURN_TIMEOUT_EN
        new_game = 1'b1;
        @(negedge clk60MHz);
        new_game = 1'b0;
        modelReset();
        waitAim();
        // throw_start on the last allowed cycle beats the timeout.
        repeat (TOUT - 1) @(negedge clk60MHz);
        throw_start = 1'b1;
        @(negedge clk60MHz);
        throw_start = 1'b0;
        checkOutput("late_throw_no_timeout", 32'(timeout), 32'd0);
        checkOutput("late_throw_flight", 32'(aim_active), 32'd0);
        throw_end = 1'b1;
        @(negedge clk60MHz);
        throw_end = 1'b0;
        resolveModel();

        // Re-enter AIM through a pause so the timer starts from zero.
        player_ready = 3'b110;
        @(negedge clk60MHz);
        player_ready = 3'b111;
        waitAim();
        for (int c = 0; c < TOUT - 1; c++) begin
            @(negedge clk60MHz);
            checkOutput("timeout_not_yet", 32'(timeout), 32'd0);
        end
        @(negedge clk60MHz);
        checkOutput("timeout_pulse", 32'(timeout), 32'd1);
        checkOutput("timeout_aim_off", 32'(aim_active), 32'd0);
        resolveModel();
        checkOutput("timeout_hp_kept", 32'(hp), modelHpPacked());
`endif

        repeat (2) @(negedge clk60MHz);
        checkOutput("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Parametrised successor to the fixed two-player turn/HP handling in the cat-vs-dog game.
- Sequences turns for NUM_PLAYERS, tracks per-player HP, skips eliminated players and declares the winner.
- Sits between choose_player/throw/simulate and the draw_hp_wind/win_loose overlays, in the clk60MHz domain.
- Consumes ready, throw-start, throw-end and hit events; produces current player, HP vector, turn counter and game status.

Parameters:
- NUM_PLAYERS, 2, number of players (2..8).
- HP_W, 7, HP width per player.
- MAX_HP, 100, HP loaded at reset/new game (must be < 2**HP_W).
- TURN_W, 3, turn counter width.
- TIMEOUT_CYCLES, 600000000, aim time limit in clk60MHz cycles (10 s); used only with TURN_TIMEOUT_EN.

Ports (PW = max(1, $clog2(NUM_PLAYERS))):
- clk60MHz  in  1  system clock; only clock.
- rst  in  1  synchronous, active-low reset.
- player_ready  in  NUM_PLAYERS  per-player ready level.
- new_game  in  1  pulse; restarts from GAME_OVER.
- throw_start  in  1  pulse; current player released a throw.
- throw_end  in  1  pulse; particle landed or left the screen.
- hit_valid  in  1  pulse; a hit is reported this cycle.
- hit_player  in  PW  index of the player hit.
- hit_damage  in  HP_W  damage amount.
- current_player  out  PW  player whose turn it is.
- aim_active  out  1  high while the current player may throw.
- turn  out  TURN_W  completed-turn counter.
- turn_pulse  out  1  one-cycle pulse on each turn advance.
- hp  out  NUM_PLAYERS*HP_W  packed HP; player i at [i*HP_W +: HP_W].
- alive  out  NUM_PLAYERS  bit i set while hp[i] > 0.
- game_over  out  1  high in GAME_OVER.
- draw  out  1  high in GAME_OVER when no player is alive.
- winner  out  PW  winning index, valid while game_over && !draw.
- timeout  out  1  one-cycle pulse on aim timeout; tied 0 without the macro.

Behaviour:
- Reset (rst==0 sampled at posedge):
  - state IDLE; current_player 0; turn 0.
  - All hp = MAX_HP; alive all 1.
  - aim_active, turn_pulse, game_over, draw, winner, timeout all 0.
- All outputs are registered.
- States: IDLE, AIM, FLIGHT, RESOLVE, GAME_OVER.
- IDLE:
  - Waits for &player_ready; then enters AIM next cycle with aim_active=1.
  - HP and current_player are preserved (resume after pause).
- AIM:
  - throw_start -> FLIGHT; aim_active drops the same edge.
  - Any player_ready bit low -> IDLE (pause). Pause wins over a simultaneous throw_start.
  - throw_end and hit_valid are ignored in AIM.
- FLIGHT:
  - On each hit_valid: hp[hit_player] -= hit_damage, saturating at 0.
  - Hits on an already-dead player, or with hit_player >= NUM_PLAYERS, are ignored.
  - Multiple hits per flight accumulate.
  - throw_end -> RESOLVE. hit_valid in the same cycle as throw_end is applied.
  - Readiness loss is ignored in FLIGHT.
- RESOLVE (exactly 1 cycle). alive is recomputed from the updated hp, then:
  - popcount(alive)==0: draw=1, game_over=1 -> GAME_OVER.
  - popcount(alive)==1: winner = that index, game_over=1 -> GAME_OVER.
  - Otherwise: current_player = next alive index after the current one, cyclically (wraps NUM_PLAYERS-1 -> 0); turn++ (wraps mod 2**TURN_W); turn_pulse=1 -> AIM.
- Latency: throw_end to turn_pulse/current_player update is 2 edges.
- GAME_OVER:
  - All event inputs are ignored.
  - new_game -> restore reset values of hp, alive, turn, current_player, draw, winner -> IDLE.
- throw_start outside AIM is ignored. new_game outside GAME_OVER is ignored.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- Defined:
  - Cycle counter runs in AIM; it is cleared on entry to AIM and on pause.
  - When the counter reaches TIMEOUT_CYCLES-1 without throw_start: timeout pulses 1 cycle and the FSM goes to RESOLVE (turn forfeited, no HP change).
  - throw_start on that same cycle wins; no timeout.
- Undefined: no counter is instantiated; timeout is constant 0.

Decomposition:
- Package game_pkg:
  - state enum turn_state_t.
  - Default constants MAX_HP_DEF and TIMEOUT_60MHZ_10S.
  - Function next_alive(mask, cur) returning the cyclic next set index.
- Sub-module hp_bank: per-player HP registers with saturating subtract, reload and the alive vector. The FSM stays in turn_sequencer.

Test Plan (NUM_PLAYERS=3, MAX_HP=100):
1. Reset low 2 cycles, then high -> hp=100/100/100, alive=3'b111, all flags 0. Set player_ready=3'b111 -> aim_active=1 after 1 cycle.
2. P0 turn: throw_start, hit (player 2, dmg 30), throw_end -> hp2=70; 2 edges after throw_end, current_player=1, turn=1, turn_pulse one cycle.
3. Hit (player 1, dmg 120) during P0 flight -> hp1=0, alive=3'b101; next player after P0 is 2, skipping 1.
4. Reduce P2 to 0 with P1 already dead -> game_over=1, winner=0, draw=0. Further hits change nothing. new_game -> hp all 100, IDLE.
5. In AIM, player_ready=3'b011 -> IDLE, aim_active=0, hp unchanged. Restore 3'b111 -> AIM with the same current_player.
6. With TURN_TIMEOUT_EN and TIMEOUT_CYCLES=16: no throw for 16 cycles -> timeout pulse, turn advances to the next alive player. throw_start on cycle 16 -> FLIGHT, no timeout.
